// File: rtl/dnn_stream_feeder_if.sv
// Host-side operand stream, datapath fire/result strobes and result stream
// seen by dnn_stream_feeder; slave is the feeder, master is its environment.
interface dnn_stream_feeder_if #(
   parameter int DW = 5,
   parameter int RW = 17
);
   logic              s_valid;
   logic [DW-1:0]     s_data;
   logic              s_ready;
   logic              reuse_w;
   logic [4*DW-1:0]   x_bus;
   logic [24*DW-1:0]  w_bus;
   logic              acc_in_ready;
   logic [RW-1:0]     acc_out0;
   logic [RW-1:0]     acc_out1;
   logic              acc_out0_ready;
   logic              acc_out1_ready;
   logic              m_valid;
   logic [RW-1:0]     m_data;
   logic              m_ready;
   logic              busy;
   logic              weights_valid;
   logic              timeout_err;

   modport slave (
      input  s_valid, s_data, reuse_w, acc_out0, acc_out1,
             acc_out0_ready, acc_out1_ready, m_ready,
      output s_ready, x_bus, w_bus, acc_in_ready, m_valid, m_data,
             busy, weights_valid, timeout_err
   );

   modport master (
      output s_valid, s_data, reuse_w, acc_out0, acc_out1,
             acc_out0_ready, acc_out1_ready, m_ready,
      input  s_ready, x_bus, w_bus, acc_in_ready, m_valid, m_data,
             busy, weights_valid, timeout_err
   );
endinterface

// File: rtl/dnn_stream_feeder.sv
// Deserialises operand frames onto x/w buses, fires one inference, collects both
// results and returns them as a 2-beat stream; s_ready only in LOAD, results held under m_ready=0.
module dnn_stream_feeder #(
   parameter int DW      = 5,
   parameter int RW      = 17,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   dnn_stream_feeder_if.slave io
);
   typedef enum logic [2:0] {S_LOAD, S_FIRE, S_WAIT, S_SEND0, S_SEND1} state_t;
   localparam int CW = $clog2(TIMEOUT) + 1;

   state_t               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d, w_idx;
   logic                 short_q, short_d, short_now, last_word, hs;
   logic [3:0][DW-1:0]   x_q, x_d;
   logic [23:0][DW-1:0]  w_q, w_d;
   logic                 wv_q, wv_d, terr_q, terr_d;
   logic                 cap0_q, cap0_d, cap1_q, cap1_d;
   logic [RW-1:0]        r0_q, r0_d, r1_q, r1_d, m_data_q;
   logic [CW-1:0]        wcnt_q, wcnt_d;
   logic                 s_ready_q, acc_in_ready_q, busy_q, m_valid_q;

   assign hs        = s_ready_q & io.s_valid;
   assign w_idx     = cnt_q - 5'd4;
   // Frame length is decided by the first word of the frame only.
   assign short_now = (cnt_q == 5'd0) ? (io.reuse_w & wv_q) : short_q;
   assign last_word = short_now ? (cnt_q == 5'd3) : (cnt_q == 5'd27);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = short_q;
      x_d     = x_q;
      w_d     = w_q;
      wv_d    = wv_q;
      terr_d  = terr_q;
      cap0_d  = cap0_q;
      cap1_d  = cap1_q;
      r0_d    = r0_q;
      r1_d    = r1_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_LOAD: begin
            if (hs) begin
               short_d = short_now;
               if (cnt_q < 5'd4) x_d[cnt_q[1:0]] = io.s_data;
               else              w_d[w_idx]      = io.s_data;
               if (last_word) begin
                  cnt_d   = '0;
                  state_d = S_FIRE;
                  if (!short_now) wv_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end
         S_FIRE: begin
            terr_d  = 1'b0;
            cap0_d  = 1'b0;
            cap1_d  = 1'b0;
            wcnt_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (io.acc_out0_ready && !cap0_q) begin
               cap0_d = 1'b1;
               r0_d   = io.acc_out0;
            end
            if (io.acc_out1_ready && !cap1_q) begin
               cap1_d = 1'b1;
               r1_d   = io.acc_out1;
            end
            wcnt_d = wcnt_q + CW'(1);
            // A capture completing in the final cycle still wins over the abort.
            if (cap0_d && cap1_d) begin
               state_d = S_SEND0;
            end else if (wcnt_q == CW'(TIMEOUT - 2)) begin
               terr_d  = 1'b1;
               state_d = S_LOAD;
            end
         end
         S_SEND0: if (io.m_ready) state_d = S_SEND1;
         S_SEND1: if (io.m_ready) state_d = S_LOAD;
         default: state_d = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_LOAD;
         cnt_q          <= '0;
         short_q        <= 1'b0;
         x_q            <= '0;
         w_q            <= '0;
         wv_q           <= 1'b0;
         terr_q         <= 1'b0;
         cap0_q         <= 1'b0;
         cap1_q         <= 1'b0;
         r0_q           <= '0;
         r1_q           <= '0;
         wcnt_q         <= '0;
         s_ready_q      <= 1'b0;
         acc_in_ready_q <= 1'b0;
         busy_q         <= 1'b0;
         m_valid_q      <= 1'b0;
         m_data_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         short_q        <= short_d;
         x_q            <= x_d;
         w_q            <= w_d;
         wv_q           <= wv_d;
         terr_q         <= terr_d;
         cap0_q         <= cap0_d;
         cap1_q         <= cap1_d;
         r0_q           <= r0_d;
         r1_q           <= r1_d;
         wcnt_q         <= wcnt_d;
         // Status outputs are registered from the next state so they read 0 in reset.
         s_ready_q      <= (state_d == S_LOAD);
         acc_in_ready_q <= (state_d == S_FIRE);
         busy_q         <= (state_d != S_LOAD);
         m_valid_q      <= (state_d == S_SEND0) || (state_d == S_SEND1);
         m_data_q       <= (state_d == S_SEND0) ? r0_d :
                           (state_d == S_SEND1) ? r1_d : '0;
      end
   end

   assign io.s_ready       = s_ready_q;
   assign io.x_bus         = x_q;
   assign io.w_bus         = w_q;
   assign io.acc_in_ready  = acc_in_ready_q;
   assign io.m_valid       = m_valid_q;
   assign io.m_data        = m_data_q;
   assign io.busy          = busy_q;
   assign io.weights_valid = wv_q;
   assign io.timeout_err   = terr_q;
endmodule

// File: tb/tb_dnn_stream_feeder.sv
// Directed bench for dnn_stream_feeder: table of frame/result vectors plus
// hand-written timeout and mid-frame reset sequences.
module tb_dnn_stream_feeder;
   localparam int DW = 5;
   localparam int RW = 17;
   localparam int TO = 64;
   localparam logic [24*DW-1:0] W_ONES = {6{20'h08421}};

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   dnn_stream_feeder_if #(.DW(DW), .RW(RW)) io();
   dnn_stream_feeder #(.DW(DW), .RW(RW), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string           nm;
      bit              full;
      int              x[4];
      logic [4*DW-1:0] exp_x;
      logic [RW-1:0]   a0;
      int              d0;
      logic [RW-1:0]   a1;
      int              d1;
      int              rep_sel;
      int              rep_d;
      logic [RW-1:0]   rep_v;
      int              stall;
      logic [RW-1:0]   e0;
      logic [RW-1:0]   e1;
   } vec_t;

   vec_t              vec[4];
   vec_t              tv;
   logic [DW-1:0]     wd[28];
   logic [24*DW-1:0]  exp_w;
   bit                mv_seen;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w, input logic reuse);
      bit   done = 0;
      logic rdy;
      io.s_valid = 1'b1;
      io.s_data  = w;
      io.reuse_w = reuse;
      for (int t = 0; t < 200 && !done; t++) begin
         rdy = io.s_ready;
         @(posedge clk); #1;
         if (rdy) done = 1;
      end
      io.s_valid = 1'b0;
      io.reuse_w = 1'b0;
      if (!done) chk("handshake_timeout", 128'(0), 128'(1));
   endtask

   task automatic send_frame(input string nm, input int n, input logic reuse);
      bit early = 0;
      for (int i = 0; i < n; i++) begin
         push_word(wd[i], (i == 0) ? reuse : 1'b0);
         if (i < n - 1 && io.acc_in_ready) early = 1;
      end
      chk({nm, "_no_early_fire"}, 128'(early), 128'(0));
      chk({nm, "_fire_pulse"}, 128'(io.acc_in_ready), 128'(1));
      chk({nm, "_busy_in_fire"}, 128'(io.busy), 128'(1));
      chk({nm, "_s_ready_low"}, 128'(io.s_ready), 128'(0));
   endtask

   task automatic run_results(input vec_t v);
      bit hold_ok = 1;
      @(posedge clk); #1;
      chk({v.nm, "_pulse_single"}, 128'(io.acc_in_ready), 128'(0));
      chk({v.nm, "_terr_clear"}, 128'(io.timeout_err), 128'(0));
      for (int k = 0; k < 8; k++) begin
         io.acc_out0_ready = (k == v.d0) || (v.rep_sel == 0 && k == v.rep_d);
         io.acc_out0 = (k == v.d0) ? v.a0 : (v.rep_sel == 0 && k == v.rep_d) ? v.rep_v : 17'h0AAAA;
         io.acc_out1_ready = (k == v.d1) || (v.rep_sel == 1 && k == v.rep_d);
         io.acc_out1 = (k == v.d1) ? v.a1 : (v.rep_sel == 1 && k == v.rep_d) ? v.rep_v : 17'h15555;
         @(posedge clk); #1;
      end
      io.acc_out0_ready = 1'b0;
      io.acc_out1_ready = 1'b0;
      for (int t = 0; t < 20 && !io.m_valid; t++) begin
         @(posedge clk); #1;
      end
      for (int s = 0; s < v.stall; s++) begin
         if (!(io.m_valid === 1'b1 && io.m_data === v.e0)) hold_ok = 0;
         @(posedge clk); #1;
      end
      chk({v.nm, "_stall_hold"}, 128'(hold_ok), 128'(1));
      chk({v.nm, "_beat0_valid"}, 128'(io.m_valid), 128'(1));
      chk({v.nm, "_beat0_data"}, 128'(io.m_data), 128'(v.e0));
      io.m_ready = 1'b1;
      @(posedge clk); #1;
      chk({v.nm, "_beat1_valid"}, 128'(io.m_valid), 128'(1));
      chk({v.nm, "_beat1_data"}, 128'(io.m_data), 128'(v.e1));
      @(posedge clk); #1;
      io.m_ready = 1'b0;
      chk({v.nm, "_valid_drop"}, 128'(io.m_valid), 128'(0));
      chk({v.nm, "_idle_busy"}, 128'(io.busy), 128'(0));
      chk({v.nm, "_back_to_load"}, 128'(io.s_ready), 128'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      io.s_valid = 1'b0; io.s_data = '0; io.reuse_w = 1'b0;
      io.acc_out0 = '0; io.acc_out1 = '0;
      io.acc_out0_ready = 1'b0; io.acc_out1_ready = 1'b0;
      io.m_ready = 1'b0;

      vec[0] = '{nm:"same_cycle", full:1'b1, x:'{1, 2, 3, 4}, exp_x:20'h20C41,
                 a0:17'sd20, d0:0, a1:-17'sd5, d1:0, rep_sel:-1, rep_d:-1, rep_v:'0,
                 stall:3, e0:17'sd20, e1:-17'sd5};
      vec[1] = '{nm:"skewed", full:1'b0, x:'{-16, 15, 0, -1}, exp_x:20'hF81F0,
                 a0:-17'sd3, d0:5, a1:17'sd7, d1:2, rep_sel:1, rep_d:6, rep_v:17'sd99,
                 stall:0, e0:-17'sd3, e1:17'sd7};
      vec[2] = '{nm:"repeat_in_wait", full:1'b0, x:'{5, 6, 7, 8}, exp_x:20'h41CC5,
                 a0:17'sd100, d0:1, a1:-17'sd65536, d1:4, rep_sel:0, rep_d:3, rep_v:17'sd5,
                 stall:0, e0:17'sd100, e1:-17'sd65536};
      vec[3] = '{nm:"extremes", full:1'b1, x:'{-1, -1, -1, -1}, exp_x:20'hFFFFF,
                 a0:17'sd65535, d0:3, a1:17'sd0, d1:3, rep_sel:-1, rep_d:-1, rep_v:'0,
                 stall:1, e0:17'sd65535, e1:17'sd0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_ready", 128'(io.s_ready), 128'(0));
      chk("rst_acc_in_ready", 128'(io.acc_in_ready), 128'(0));
      chk("rst_m_valid", 128'(io.m_valid), 128'(0));
      chk("rst_busy", 128'(io.busy), 128'(0));
      chk("rst_weights_valid", 128'(io.weights_valid), 128'(0));
      chk("rst_timeout_err", 128'(io.timeout_err), 128'(0));
      chk("rst_m_data", 128'(io.m_data), 128'(0));
      chk("rst_x_bus", 128'(io.x_bus), 128'(0));
      chk("rst_w_bus", 128'(io.w_bus), 128'(0));
      rst_n = 1'b1;

      foreach (vec[v]) begin
         for (int i = 0; i < 4; i++) wd[i] = DW'(vec[v].x[i]);
         for (int j = 0; j < 24; j++) wd[4 + j] = DW'(1);
         send_frame(vec[v].nm, vec[v].full ? 28 : 4, !vec[v].full);
         chk({vec[v].nm, "_x_bus"}, 128'(io.x_bus), 128'(vec[v].exp_x));
         chk({vec[v].nm, "_w_bus"}, 128'(io.w_bus), 128'(W_ONES));
         chk({vec[v].nm, "_weights_valid"}, 128'(io.weights_valid), 128'(1));
         run_results(vec[v]);
      end

      // Timeout: no strobes after the fire.
      for (int i = 0; i < 4; i++) wd[i] = DW'(2);
      send_frame("timeout", 4, 1'b1);
      mv_seen = 0;
      for (int i = 0; i < TO - 1; i++) begin
         @(posedge clk); #1;
         mv_seen |= io.m_valid;
      end
      chk("timeout_not_yet", 128'(io.timeout_err), 128'(0));
      chk("timeout_busy_in_wait", 128'(io.busy), 128'(1));
      @(posedge clk); #1;
      mv_seen |= io.m_valid;
      chk("timeout_err_set", 128'(io.timeout_err), 128'(1));
      chk("timeout_to_load", 128'(io.s_ready), 128'(1));
      chk("timeout_not_busy", 128'(io.busy), 128'(0));
      chk("timeout_no_beats", 128'(mv_seen), 128'(0));
      chk("timeout_x_kept", 128'(io.x_bus), 128'(20'h10842));
      chk("timeout_w_kept", 128'(io.w_bus), 128'(W_ONES));
      chk("timeout_wv_kept", 128'(io.weights_valid), 128'(1));

      for (int i = 0; i < 4; i++) wd[i] = DW'(3);
      send_frame("after_timeout", 4, 1'b1);
      tv = '{nm:"after_timeout", full:1'b0, x:'{3, 3, 3, 3}, exp_x:20'h18C63,
             a0:17'sd1, d0:1, a1:17'sd2, d1:1, rep_sel:-1, rep_d:-1, rep_v:'0,
             stall:0, e0:17'sd1, e1:17'sd2};
      run_results(tv);

      // Mid-frame reset discards the partial frame and the weight set.
      for (int i = 0; i < 28; i++) wd[i] = DW'(i + 3);
      for (int i = 0; i < 10; i++) push_word(wd[i], 1'b0);
      rst_n = 1'b0;
      #2;
      chk("midrst_weights_valid", 128'(io.weights_valid), 128'(0));
      chk("midrst_x_bus", 128'(io.x_bus), 128'(0));
      chk("midrst_w_bus", 128'(io.w_bus), 128'(0));
      chk("midrst_s_ready", 128'(io.s_ready), 128'(0));
      chk("midrst_timeout_err", 128'(io.timeout_err), 128'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) wd[i] = DW'(i + 1);
      for (int j = 0; j < 24; j++) begin
         wd[4 + j] = DW'(j - 8);
         exp_w[DW*j +: DW] = DW'(j - 8);
      end
      send_frame("reuse_no_weights", 28, 1'b1);
      chk("reuse_no_weights_x_bus", 128'(io.x_bus), 128'(20'h20C41));
      chk("reuse_no_weights_w_bus", 128'(io.w_bus), 128'(exp_w));
      chk("reuse_no_weights_wv", 128'(io.weights_valid), 128'(1));
      tv = '{nm:"after_reset", full:1'b1, x:'{1, 2, 3, 4}, exp_x:20'h20C41,
             a0:-17'sd1, d0:7, a1:-17'sd2, d1:0, rep_sel:-1, rep_d:-1, rep_v:'0,
             stall:2, e0:-17'sd1, e1:-17'sd2};
      run_results(tv);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
